// File: rtl/data_bus_arbiter_pkg.sv
// Shared constants for the processor data bus arbiter and its request picker.
// The arbiter top is data_bus_arbiter; the sub-module is data_bus_arbiter_rr_pick.
package data_bus_arbiter_pkg;

   localparam logic [1:0] ARB_IDLE  = 2'd0;
   localparam logic [1:0] ARB_GRANT = 2'd1;
   localparam logic [1:0] ARB_HOLD  = 2'd2;

   localparam int REQ_FETCH     = 0;
   localparam int REQ_REGFILE   = 1;
   localparam int REQ_COMPUTE   = 2;
   localparam int REQ_INTERFACE = 3;

   localparam int DEFAULT_DATA_W = 16;

endpackage

// File: rtl/data_bus_arbiter_rr_pick.sv
// Combinational one-hot picker: first eligible request found when scanning upward
// from the start pointer (wrapping), skipping any index set in the exclude mask.
module data_bus_arbiter_rr_pick #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req_i,
   input  logic [$clog2(N_REQ)-1:0] ptr_i,
   input  logic [N_REQ-1:0]         excl_i,
   output logic [N_REQ-1:0]         gnt_o,
   output logic [$clog2(N_REQ)-1:0] idx_o,
   output logic                     any_o
);
   localparam int PTR_W = $clog2(N_REQ);

   logic [N_REQ-1:0] eligible;
   logic [PTR_W-1:0] slot;

   assign eligible = req_i & ~excl_i;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      slot  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         slot = PTR_W'((int'(ptr_i) + i) % N_REQ);
         if (!any_o && eligible[slot]) begin
            gnt_o[slot] = 1'b1;
            idx_o       = slot;
            any_o       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/data_bus_arbiter.sv
// Shared data bus arbiter: one-hot registered grant, optional locked hold with forced
// release at MAX_HOLD. Define ARB_FIXED_PRIO_EN for lowest-index priority instead of round-robin.
module data_bus_arbiter
   import data_bus_arbiter_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int DATA_W   = DEFAULT_DATA_W,
   parameter int MAX_HOLD = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        i_req,
   input  logic [N_REQ-1:0]        i_lock,
   input  logic [N_REQ*DATA_W-1:0] i_data,
   output logic [N_REQ-1:0]        o_gnt,
   output logic [DATA_W-1:0]       o_data,
   output logic                    o_valid,
   output logic                    o_timeout
);
   localparam int PTR_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(MAX_HOLD);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_HOLD - 1);

   logic [1:0]        state_q, state_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic [PTR_W-1:0]  gIdx_q, gIdx_d;
   logic [CNT_W-1:0]  holdCnt_q, holdCnt_d;
   logic [DATA_W-1:0] data_q, busWord;
   logic              valid_q;
   logic              timeout_q, timeout_d;
   logic              keepLock, forceRel, stayLocked;
   logic [PTR_W-1:0]  searchBase, pickIdx;
   logic [N_REQ-1:0]  exclMask, pickGnt;
   logic              pickAny;

   // The current holder keeps the bus only while it locks and has hold budget left.
   assign keepLock   = i_req[gIdx_q] & i_lock[gIdx_q];
   assign forceRel   = (state_q == ARB_HOLD) && keepLock && (holdCnt_q == LAST_CNT);
   assign stayLocked = (state_q != ARB_IDLE) && keepLock && !forceRel;
   assign exclMask   = forceRel ? gnt_q : '0;

`ifdef ARB_FIXED_PRIO_EN
   assign searchBase = '0;
`else
   logic [PTR_W-1:0] ptr_q, ptr_d, nextPtr;

   assign nextPtr    = (gIdx_q == PTR_W'(N_REQ - 1)) ? '0 : gIdx_q + PTR_W'(1);
   assign searchBase = (state_q == ARB_IDLE) ? ptr_q : nextPtr;
   assign ptr_d      = ((state_q != ARB_IDLE) && !stayLocked) ? nextPtr : ptr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   data_bus_arbiter_rr_pick #(
      .N_REQ (N_REQ)
   ) u_rr_pick (
      .req_i  (i_req),
      .ptr_i  (searchBase),
      .excl_i (exclMask),
      .gnt_o  (pickGnt),
      .idx_o  (pickIdx),
      .any_o  (pickAny)
   );

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      gIdx_d    = gIdx_q;
      holdCnt_d = holdCnt_q;
      timeout_d = 1'b0;
      if (stayLocked) begin
         state_d   = ARB_HOLD;
         holdCnt_d = (state_q == ARB_GRANT) ? CNT_W'(1) : holdCnt_q + CNT_W'(1);
      end else begin
         timeout_d = forceRel;
         holdCnt_d = '0;
         if (pickAny) begin
            state_d = ARB_GRANT;
            gnt_d   = pickGnt;
            gIdx_d  = pickIdx;
         end else begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
         end
      end
   end

   always_comb begin
      busWord = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (gnt_q[k]) begin
            busWord = busWord | i_data[k*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ARB_IDLE;
         gnt_q     <= '0;
         gIdx_q    <= '0;
         holdCnt_q <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         gIdx_q    <= gIdx_d;
         holdCnt_q <= holdCnt_d;
         timeout_q <= timeout_d;
         valid_q   <= |gnt_q;
         if (|gnt_q) begin
            data_q <= busWord;
         end
      end
   end

   assign o_gnt     = gnt_q;
   assign o_data    = data_q;
   assign o_valid   = valid_q;
   assign o_timeout = timeout_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Scoreboard bench for data_bus_arbiter: a grant-level reference model predicts each cycle,
// and a negedge monitor pops and compares whatever the DUT presents.
module tb_data_bus_arbiter;

   localparam int N        = 4;
   localparam int DW       = 16;
   localparam int MAX_HOLD = 8;

   typedef struct {
      logic [N-1:0] gnt;
      logic         valid;
      logic         timeout;
   } expCtrl_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    i_req = '0;
   logic [N-1:0]    i_lock = '0;
   logic [N*DW-1:0] i_data = '0;
   logic [N-1:0]    o_gnt;
   logic [DW-1:0]   o_data;
   logic            o_valid;
   logic            o_timeout;

   int total = 0;
   int bad = 0;

   expCtrl_t        ctrlQ[$];
   logic [DW-1:0]   dataQ[$];

   // reference model state: granted requester (-1 none), cycles in this run, rr pointer
   int cur = -1;
   int runLen = 0;
   int ptr = 0;

   data_bus_arbiter #(
      .N_REQ    (N),
      .DATA_W   (DW),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_req     (i_req),
      .i_lock    (i_lock),
      .i_data    (i_data),
      .o_gnt     (o_gnt),
      .o_data    (o_data),
      .o_valid   (o_valid),
      .o_timeout (o_timeout)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   function automatic int pickFn(input logic [N-1:0] req, input int base, input int excl);
      int b;
`ifdef ARB_FIXED_PRIO_EN
      b = 0;
`else
      b = base;
`endif
      for (int i = 0; i < N; i++) begin
         int k;
         k = (b + i) % N;
         if (req[k] && k != excl) return k;
      end
      return -1;
   endfunction

   task automatic modelStep();
      expCtrl_t e;
      int nxt;
      bit forced;
      forced = 1'b0;
      e.valid = (cur >= 0);
      if (cur >= 0) dataQ.push_back(i_data[cur*DW +: DW]);
      if (cur < 0) begin
         nxt = pickFn(i_req, ptr, -1);
         runLen = (nxt >= 0) ? 1 : 0;
      end else if (i_req[cur] && i_lock[cur] && runLen < MAX_HOLD) begin
         nxt = cur;
         runLen++;
      end else begin
         forced = i_req[cur] && i_lock[cur];
         ptr = (cur + 1) % N;
         nxt = pickFn(i_req, ptr, forced ? cur : -1);
         runLen = (nxt >= 0) ? 1 : 0;
      end
      e.gnt = (nxt >= 0) ? N'(1 << nxt) : '0;
      e.timeout = forced;
      ctrlQ.push_back(e);
      cur = nxt;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            cur = -1;
            runLen = 0;
            ptr = 0;
         end else begin
            modelStep();
         end
      end
   end

   // monitor: reset values while rst_n is low, otherwise pop the scoreboard
   initial begin
      expCtrl_t e;
      logic [DW-1:0] lastData;
      lastData = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            lastData = '0;
            checkOutput("reset gnt", 32'(o_gnt), 32'd0);
            checkOutput("reset valid", 32'(o_valid), 32'd0);
            checkOutput("reset timeout", 32'(o_timeout), 32'd0);
            checkOutput("reset data", 32'(o_data), 32'd0);
         end else if (ctrlQ.size() == 0) begin
            checkOutput("ctrl queue underrun", 32'd0, 32'd1);
         end else begin
            e = ctrlQ.pop_front();
            checkOutput("gnt", 32'(o_gnt), 32'(e.gnt));
            checkOutput("valid", 32'(o_valid), 32'(e.valid));
            checkOutput("timeout", 32'(o_timeout), 32'(e.timeout));
            if (o_valid) begin
               if (dataQ.size() == 0) begin
                  checkOutput("data queue underrun", 32'd0, 32'd1);
               end else begin
                  lastData = dataQ.pop_front();
                  checkOutput("data", 32'(o_data), 32'(lastData));
               end
            end else begin
               checkOutput("data hold", 32'(o_data), 32'(lastData));
            end
         end
      end
   end

   task automatic applyStimulus(input logic [N-1:0] req, input logic [N-1:0] lock, input logic [N*DW-1:0] data);
      @(negedge clk);
      #1;
      i_req  = req;
      i_lock = lock;
      i_data = data;
   endtask

   function automatic logic [N*DW-1:0] randData();
      logic [N*DW-1:0] d;
      for (int k = 0; k < N; k++) d[k*DW +: DW] = DW'($urandom);
      return d;
   endfunction

   initial begin
      logic [N*DW-1:0] wordA;
      logic [N-1:0] lk;

      // reset with every requester asking, then round-robin rotation
      rst_n  = 1'b0;
      i_req  = 4'b1111;
      i_data = randData();
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) applyStimulus(4'b1111, 4'b0000, randData());

      // single requester with a known word, then drop
      wordA = randData();
      wordA[2*DW +: DW] = 16'hA5C3;
      applyStimulus(4'b0100, 4'b0000, wordA);
      applyStimulus(4'b0000, 4'b0000, wordA);
      repeat (3) applyStimulus(4'b0000, 4'b0000, randData());

      // short lock then hand-over without a bubble
      repeat (3) applyStimulus(4'b0011, 4'b0001, randData());
      repeat (3) applyStimulus(4'b0011, 4'b0000, randData());
      repeat (2) applyStimulus(4'b0000, 4'b0000, randData());

      // lock held past MAX_HOLD forces release
      repeat (20) applyStimulus(4'b0011, 4'b0001, randData());
      repeat (2) applyStimulus(4'b0000, 4'b0000, randData());

      // asynchronous reset in the middle of a hold
      repeat (4) applyStimulus(4'b0011, 4'b0001, randData());
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async reset gnt", 32'(o_gnt), 32'd0);
      checkOutput("async reset valid", 32'(o_valid), 32'd0);
      checkOutput("async reset timeout", 32'(o_timeout), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) applyStimulus(4'b0000, 4'b0000, randData());

`ifdef ARB_FIXED_PRIO_EN
      repeat (6) applyStimulus(4'b1010, 4'b0000, randData());
`endif

      // randomized traffic, locks biased high so forced releases occur
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) != 0) lk = 4'b1111;
         else lk = N'($urandom);
         applyStimulus(N'($urandom), lk, randData());
      end
      repeat (3) applyStimulus(4'b0000, 4'b0000, randData());
      @(negedge clk);
      #1;
      checkOutput("data queue drained", 32'(dataQ.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
